// File: rtl/keypad_operand_entry.sv
// Keypad operand entry: accumulates decimal digit keys into a binary
// operand and offers it to the arithmetic unit on ENTER.
module keypad_operand_entry #(
    parameter int DIGITS = 2,
    parameter int WIDTH  = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    output logic [WIDTH-1:0] value,
    output logic [1:0]       digit_cnt,
    output logic             key_err,
    output logic             entry_valid,
    output logic [WIDTH-1:0] entry_value,
    input  logic             entry_ready
);

    typedef enum logic {
        ENTRY = 1'b0,
        HOLD  = 1'b1
    } state_e;

    localparam logic [3:0] KEY_BS  = 4'hA;
    localparam logic [3:0] KEY_CLR = 4'hB;
    localparam logic [3:0] KEY_ENT = 4'hC;
    localparam logic [1:0] MAXCNT  = 2'(DIGITS);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             ev_q, ev_d;
    logic [WIDTH-1:0] eval_q, eval_d;

    logic [WIDTH-1:0] times10;
    logic [WIDTH-1:0] div10;
    logic             is_digit;
    logic             is_bs;
    logic             is_clr;
    logic             is_ent;

    // value*10+d built from shifts at WIDTH+4 bits; never exceeds range
    assign times10 = WIDTH'(({4'b0, value_q} << 3)
                          + ({4'b0, value_q} << 1)
                          + {{WIDTH{1'b0}}, key_code});
    assign div10    = value_q / WIDTH'(10);
    assign is_digit = (key_code <= 4'd9);
    assign is_bs    = (key_code == KEY_BS);
    assign is_clr   = (key_code == KEY_CLR);
    assign is_ent   = (key_code == KEY_ENT);

    // Next-state: key decode in ENTRY, handshake wait in HOLD
    always_comb begin
        state_d = state_q;
        value_d = value_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        ev_d    = ev_q;
        eval_d  = eval_q;
        unique case (state_q)
            ENTRY: begin
                if (key_valid) begin
                    unique case (1'b1)
                        is_digit: begin
                            if (cnt_q < MAXCNT) begin
                                value_d = times10;
                                cnt_d   = cnt_q + 2'd1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        is_bs: begin
                            if (cnt_q != 2'd0) begin
                                value_d = div10;
                                cnt_d   = cnt_q - 2'd1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        is_clr: begin
                            value_d = '0;
                            cnt_d   = 2'd0;
                        end
                        is_ent: begin
                            if (cnt_q != 2'd0) begin
                                eval_d  = value_q;
                                ev_d    = 1'b1;
                                value_d = '0;
                                cnt_d   = 2'd0;
                                state_d = HOLD;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            HOLD: begin
                err_d = key_valid;
                if (ev_q && entry_ready) begin
                    ev_d    = 1'b0;
                    state_d = ENTRY;
                end
            end
        endcase
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ENTRY;
            value_q <= '0;
            cnt_q   <= 2'd0;
            err_q   <= 1'b0;
            ev_q    <= 1'b0;
            eval_q  <= '0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ev_q    <= ev_d;
            eval_q  <= eval_d;
        end
    end

    assign value       = value_q;
    assign digit_cnt   = cnt_q;
    assign key_err     = err_q;
    assign entry_valid = ev_q;
    assign entry_value = eval_q;

endmodule
